divider_fp8_seq: RTL and testbench

// - Sequential FP8 divider (1 sign, 3 exp, 4 mantissa, bias 3): result = a / b.
// - Inverse-operation companion to the combinational FP8 multiplier: same encoding, same special-value rules.
// - Restoring division produces one quotient bit per clock.
// - valid/ready handshake on both sides; sits beside the multiplier in the FP8 arithmetic unit.

---
 rtl/fp8_pkg.sv | 43 ++++
 rtl/adder_nbit_cin.sv | 14 +
 rtl/fp8_unpack.sv | 16 +
 rtl/divider_fp8_seq.sv | 212 +++++++++++++++++++++
 tb/tb_divider_fp8_seq.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp8_pkg.sv
// Shared FP8 (1/3/4, bias 3) constants, encodings, FSM states and operand classification.
package fp8_pkg;

    localparam int unsigned EXP_W   = 3;
    localparam int unsigned MAN_W   = 4;
    localparam int unsigned BIAS    = 3;
    localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned REM_W   = SIG_W + 1;
    localparam int unsigned Q_W     = MAN_W + 3;
    localparam int unsigned E_W     = EXP_W + 2;
    localparam int unsigned CNT_W   = $clog2(Q_W);
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [FP_W-2:0] QNAN = 7'h7F;
    localparam logic [FP_W-2:0] INF  = 7'h70;
    localparam logic [FP_W-2:0] ZERO = 7'h00;

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp8_class_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        fp8_class_t       cls;
    } fp8_unpacked_t;

    // Exp field 0 is flushed to zero regardless of mantissa.
    function automatic fp8_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        fp8_class_t c;
        c.is_nan  = (e == '1) && (m != '0);
        c.is_inf  = (e == '1) && (m == '0);
        c.is_zero = (e == '0);
        return c;
    endfunction

endpackage

// File: rtl/adder_nbit_cin.sv
// Plain W-bit adder with carry in/out; subtract by feeding ~b and cin=1.
module adder_nbit_cin #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum_c,
    output logic         o_cout_c
);

    assign {o_cout_c, o_sum_c} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/fp8_unpack.sv
// Splits an FP8 operand into sign/exponent/significand and tags special classes.
module fp8_unpack
    import fp8_pkg::*;
(
    input  logic [FP_W-1:0] i_x,
    output fp8_unpacked_t   o_op_c
);

    always_comb begin
        o_op_c.sign = i_x[FP_W-1];
        o_op_c.exp  = i_x[FP_W-2:MAN_W];
        o_op_c.sig  = {1'b1, i_x[MAN_W-1:0]};
        o_op_c.cls  = classify(i_x[FP_W-2:MAN_W], i_x[MAN_W-1:0]);
    end

endmodule

// File: rtl/divider_fp8_seq.sv
// Sequential FP8 divider: restoring division, one quotient bit per clock,
// valid/ready on both sides, special operands resolved straight at accept.
module divider_fp8_seq
    import fp8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            flag_invalid,
    output logic            flag_divzero,
    output logic            flag_ovf,
    output logic            flag_unf
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [FP_W-1:0]   r_result;
    logic              r_flag_invalid;
    logic              r_flag_divzero;
    logic              r_flag_ovf;
    logic              r_flag_unf;
    logic              r_sign;
    logic [EXP_W-1:0]  r_ea;
    logic [EXP_W-1:0]  r_eb;
    logic [SIG_W-1:0]  r_b;
    logic [REM_W-1:0]  r_rem;
    logic [Q_W-1:0]    r_q;
    logic [CNT_W-1:0]  r_cnt;

    fp8_unpacked_t     w_ua;
    fp8_unpacked_t     w_ub;
    logic              w_accept;
    logic              w_special;
    logic              w_sign;
    logic [FP_W-2:0]   w_sp_code;
    logic              w_sp_invalid;
    logic              w_sp_divzero;

    fp8_unpack u_unpack_a (.i_x(a), .o_op_c(w_ua));
    fp8_unpack u_unpack_b (.i_x(b), .o_op_c(w_ub));

    assign w_accept  = in_valid & r_in_ready;
    assign w_sign    = w_ua.sign ^ w_ub.sign;
    assign w_special = (|w_ua.cls) | (|w_ub.cls);

    // Special-operand result, highest priority first.
    always_comb begin
        w_sp_code    = ZERO;
        w_sp_invalid = 1'b0;
        w_sp_divzero = 1'b0;
        if (w_ua.cls.is_nan || w_ub.cls.is_nan || (w_ua.cls.is_zero && w_ub.cls.is_zero)
            || (w_ua.cls.is_inf && w_ub.cls.is_inf)) begin
            w_sp_code    = QNAN;
            w_sp_invalid = 1'b1;
        end else if (w_ua.cls.is_inf) begin
            w_sp_code = INF;
        end else if (w_ub.cls.is_zero) begin
            w_sp_code    = INF;
            w_sp_divzero = 1'b1;
        end
    end

    // Restoring step: carry-out of R + ~B + 1 means R >= B.
    logic [REM_W-1:0] w_b_inv;
    logic [REM_W-1:0] w_rem_diff;
    logic [REM_W-1:0] w_rem_sel;
    logic             w_rem_ge;

    assign w_b_inv = ~REM_W'(r_b);

    adder_nbit_cin #(.W(REM_W)) u_rem_sub (
        .i_a(r_rem), .i_b(w_b_inv), .i_cin(1'b1), .o_sum_c(w_rem_diff), .o_cout_c(w_rem_ge)
    );

    assign w_rem_sel = w_rem_ge ? w_rem_diff : r_rem;

    // Normalise, round half-up, compute biased exponent.
    logic             w_q_msb;
    logic [MAN_W-1:0] w_mant_pre;
    logic             w_guard;
    logic [MAN_W-1:0] w_mant_rnd;
    logic             w_rnd_carry;
    logic [EXP_W-1:0] w_eb_inv;
    logic [EXP_W-1:0] w_esub_sum;
    logic             w_esub_cout;
    logic [E_W-1:0]   w_ediff;
    logic [E_W-1:0]   w_bias;
    logic [E_W-1:0]   w_ebias_sum;
    logic             w_ebias_cout;
    logic [E_W:0]     w_exp;
    logic             w_norm_ovf;
    logic             w_norm_unf;
    logic [FP_W-2:0]  w_norm_code;

    assign w_q_msb    = r_q[Q_W-1];
    assign w_mant_pre = w_q_msb ? r_q[MAN_W+1:2] : r_q[MAN_W:1];
    assign w_guard    = w_q_msb ? r_q[1] : r_q[0];

    adder_nbit_cin #(.W(MAN_W)) u_rnd (
        .i_a(w_mant_pre), .i_b({MAN_W{1'b0}}), .i_cin(w_guard),
        .o_sum_c(w_mant_rnd), .o_cout_c(w_rnd_carry)
    );

    assign w_eb_inv = ~r_eb;

    adder_nbit_cin #(.W(EXP_W)) u_exp_sub (
        .i_a(r_ea), .i_b(w_eb_inv), .i_cin(1'b1), .o_sum_c(w_esub_sum), .o_cout_c(w_esub_cout)
    );

    // No carry out means ea < eb: sign-extend the difference as negative.
    assign w_ediff = {{(E_W-EXP_W){~w_esub_cout}}, w_esub_sum};
    assign w_bias  = w_q_msb ? E_W'(BIAS) : E_W'(BIAS - 1);

    adder_nbit_cin #(.W(E_W)) u_exp_bias (
        .i_a(w_ediff), .i_b(w_bias), .i_cin(w_rnd_carry),
        .o_sum_c(w_ebias_sum), .o_cout_c(w_ebias_cout)
    );

    assign w_exp       = {w_ediff[E_W-1] ^ w_ebias_cout, w_ebias_sum};
    assign w_norm_ovf  = ~w_exp[E_W] & (w_exp[E_W-1:0] >= E_W'(EXP_MAX));
    assign w_norm_unf  = w_exp[E_W] | (w_exp == '0);
    assign w_norm_code = w_norm_ovf ? INF : (w_norm_unf ? ZERO : {w_exp[EXP_W-1:0], w_mant_rnd});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : DIV;
            DIV:     if (r_cnt == CNT_W'(Q_W - 1)) w_state_nxt = NORM;
            NORM:    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_result       <= '0;
            r_flag_invalid <= 1'b0;
            r_flag_divzero <= 1'b0;
            r_flag_ovf     <= 1'b0;
            r_flag_unf     <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (r_state == IDLE && w_accept && w_special) begin
                r_result       <= {w_sign, w_sp_code};
                r_flag_invalid <= w_sp_invalid;
                r_flag_divzero <= w_sp_divzero;
                r_flag_ovf     <= 1'b0;
                r_flag_unf     <= 1'b0;
            end else if (r_state == NORM) begin
                r_result       <= {r_sign, w_norm_code};
                r_flag_invalid <= 1'b0;
                r_flag_divzero <= 1'b0;
                r_flag_ovf     <= w_norm_ovf;
                r_flag_unf     <= w_norm_unf;
            end
        end
    end

    // Operand latch and division datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_ea   <= '0;
            r_eb   <= '0;
            r_b    <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_sign <= w_sign;
            r_ea   <= w_ua.exp;
            r_eb   <= w_ub.exp;
            r_b    <= w_ub.sig;
            r_rem  <= REM_W'(w_ua.sig);
            r_q    <= '0;
            r_cnt  <= '0;
        end else if (r_state == DIV) begin
            r_rem  <= w_rem_sel << 1;
            r_q    <= {r_q[Q_W-2:0], w_rem_ge};
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign flag_invalid = r_flag_invalid;
    assign flag_divzero = r_flag_divzero;
    assign flag_ovf     = r_flag_ovf;
    assign flag_unf     = r_flag_unf;

endmodule

// File: tb/tb_divider_fp8_seq.sv
// Directed self-checking bench for divider_fp8_seq; flags packed as {invalid, divzero, ovf, unf}.
module tb_divider_fp8_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_invalid;
    logic       flag_divzero;
    logic       flag_ovf;
    logic       flag_unf;

    int checks = 0;
    int errors = 0;

    divider_fp8_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_invalid(flag_invalid), .flag_divzero(flag_divzero),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one operation and wait for out_valid; cyc counts clock edges from (and including) the accepting edge.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          output logic [7:0] res, output logic [3:0] flg, output int cyc);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1 (a=%h b=%h)", in_ready, ia, ib);
        end
        a = ia;
        b = ib;
        in_valid = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1 (a=%h b=%h)", out_valid, ia, ib);
        end
        res = result;
        flg = {flag_invalid, flag_divzero, flag_ovf, flag_unf};
    endtask

    task automatic accept_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({result, flag_invalid, flag_divzero, flag_ovf, flag_unf} !== 12'h000) begin
            errors++;
            $display("FAIL reset_result_flags: got %h/%b%b%b%b expected 00/0000",
                     result, flag_invalid, flag_divzero, flag_ovf, flag_unf);
        end
    endtask

    task automatic test_normal();
        logic [7:0] va [0:3];
        logic [7:0] vb [0:3];
        logic [7:0] vr [0:3];
        logic [7:0] res;
        logic [3:0] flg;
        int         cyc;
        va = '{8'h48, 8'h30, 8'h30, 8'hC8};
        vb = '{8'h40, 8'h48, 8'h33, 8'h40};
        vr = '{8'h38, 8'h15, 8'h2B, 8'hB8};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], res, flg, cyc);
            checks++;
            if (res !== vr[i]) begin
                errors++;
                $display("FAIL normal_result %h/%h: got %h expected %h", va[i], vb[i], res, vr[i]);
            end
            checks++;
            if (flg !== 4'b0000) begin
                errors++;
                $display("FAIL normal_flags %h/%h: got %b expected 0000", va[i], vb[i], flg);
            end
            checks++;
            if (cyc - 1 !== 8) begin
                errors++;
                $display("FAIL normal_latency %h/%h: got %0d clocks after accept edge expected 8",
                         va[i], vb[i], cyc - 1);
            end
            accept_out();
        end
    endtask

    task automatic test_range();
        logic [7:0] va [0:1];
        logic [7:0] vb [0:1];
        logic [7:0] vr [0:1];
        logic [3:0] vf [0:1];
        logic [7:0] res;
        logic [3:0] flg;
        int         cyc;
        va = '{8'h6F, 8'h10};
        vb = '{8'h10, 8'h6F};
        vr = '{8'h70, 8'h00};
        vf = '{4'b0010, 4'b0001};
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], res, flg, cyc);
            checks++;
            if (res !== vr[i] || flg !== vf[i]) begin
                errors++;
                $display("FAIL range %h/%h: got %h/%b expected %h/%b", va[i], vb[i], res, flg, vr[i], vf[i]);
            end
            accept_out();
        end
    endtask

    task automatic test_special();
        logic [7:0] va [0:8];
        logic [7:0] vb [0:8];
        logic [7:0] vr [0:8];
        logic [3:0] vf [0:8];
        logic [7:0] res;
        logic [3:0] flg;
        int         cyc;
        va = '{8'hB0, 8'h00, 8'h70, 8'h70, 8'h00, 8'h48, 8'h30, 8'hF0, 8'h48};
        vb = '{8'h00, 8'h00, 8'h70, 8'h30, 8'h40, 8'h78, 8'h70, 8'h00, 8'h0F};
        vr = '{8'hF0, 8'h7F, 8'h7F, 8'h70, 8'h00, 8'h7F, 8'h00, 8'hF0, 8'h70};
        vf = '{4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0100};
        for (int i = 0; i < 9; i++) begin
            run_op(va[i], vb[i], res, flg, cyc);
            checks++;
            if (res !== vr[i] || flg !== vf[i]) begin
                errors++;
                $display("FAIL special %h/%h: got %h/%b expected %h/%b", va[i], vb[i], res, flg, vr[i], vf[i]);
            end
            checks++;
            if (cyc !== 1) begin
                errors++;
                $display("FAIL special_latency %h/%h: got %0d expected 1", va[i], vb[i], cyc);
            end
            accept_out();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] res;
        logic [3:0] flg;
        int         cyc;
        run_op(8'h48, 8'h40, res, flg, cyc);
        checks++;
        if (res !== 8'h38) begin
            errors++;
            $display("FAIL bp_result: got %h expected 38", res);
        end
        a = 8'h10;
        b = 8'h10;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 8'h38 || in_ready !== 1'b0
                || {flag_invalid, flag_divzero, flag_ovf, flag_unf} !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b result=%h in_ready=%b expected 1/38/0",
                         i, out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_handoff: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] res;
        logic [3:0] flg;
        int         cyc;
        logic       seen_valid;
        @(negedge clk);
        a = 8'h48;
        b = 8'h40;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_output: out_valid seen=%b expected 0", seen_valid);
        end
        run_op(8'h40, 8'h30, res, flg, cyc);
        checks++;
        if (res !== 8'h40 || flg !== 4'b0000 || cyc - 1 !== 8) begin
            errors++;
            $display("FAIL after_abort: got %h/%b lat %0d expected 40/0000 lat 8", res, flg, cyc - 1);
        end
        accept_out();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        test_reset();
        test_normal();
        test_range();
        test_special();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
